// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read per fetch phase,
// stalls the phase counter while the read is outstanding, and advances the PC on commit.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            phase_fetch,
  input  logic            phase_commit,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_err,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic            stall,
  output logic            fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            phase_fetch_q, phase_commit_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            fault_q, fault_d;
  logic            fetch_rise, commit_rise;
  logic [XLEN-1:0] next_pc;

  // Sequential successor or branch target; the add wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] calc_next_pc(
    input logic [XLEN-1:0] cur,
    input logic            taken,
    input logic [XLEN-1:0] target
  );
    if (taken) begin
      return target;
    end
    return cur + XLEN'(4);
  endfunction

  function automatic logic is_misaligned(
    input logic            taken,
    input logic [XLEN-1:0] target
  );
    return taken && (target[1:0] != 2'b00);
  endfunction

  assign fetch_rise  = phase_fetch & ~phase_fetch_q;
  assign commit_rise = phase_commit & ~phase_commit_q;
  assign next_pc     = calc_next_pc(pc_q, branch_taken, branch_target);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    case (state_q)
      IDLE: begin
        if (fetch_rise) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (imem_err) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end
      end
      HOLD: begin
        if (commit_rise) begin
          if (is_misaligned(branch_taken, branch_target)) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            pc_d          = next_pc;
            instr_valid_d = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      phase_fetch_q  <= 1'b0;
      phase_commit_q <= 1'b0;
      pc_q           <= RESET_PC;
      instr_q        <= NOP;
      instr_valid_q  <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_fetch_q  <= phase_fetch;
      phase_commit_q <= phase_commit;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      instr_valid_q  <= instr_valid_d;
      fault_q        <= fault_d;
    end
  end

  // A fetch level present during reset must not show up as stall until release.
  assign stall       = ~rst & (fetch_rise | (state_q == REQ) | (state_q == FAULT));
  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, zero-wait and waited fetch, branch/wrap,
// misaligned branch, bus error and reset during an outstanding request.
module tb_fetch_unit;

  localparam int          XLEN = 32;
  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            phase_fetch = 1'b0;
  logic            phase_commit = 1'b0;
  logic            branch_taken = 1'b0;
  logic [XLEN-1:0] branch_target = '0;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic            imem_err = 1'b0;
  logic [31:0]     instr;
  logic            instr_valid;
  logic [XLEN-1:0] pc;
  logic            stall;
  logic            fault;

  int checks   = 0;
  int failures = 0;
  int st_cnt   = 0;
  int rq_cnt   = 0;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .phase_fetch  (phase_fetch),
    .phase_commit (phase_commit),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .imem_err     (imem_err),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .stall        (stall),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs are set at posedge+1; sample at negedge, then move to next posedge+1.
  task automatic run_cycle();
    @(negedge clk);
    if (stall) st_cnt++;
    if (imem_req) rq_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] rd, input logic err);
    phase_fetch = 1'b1;
    run_cycle();
    phase_fetch = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = rd;
    imem_err    = err;
    run_cycle();
    imem_ack = 1'b0;
    imem_err = 1'b0;
    run_cycle();
  endtask

  task automatic do_commit(input logic taken, input logic [31:0] tgt);
    phase_commit  = 1'b1;
    branch_taken  = taken;
    branch_target = tgt;
    run_cycle();
    phase_commit = 1'b0;
    branch_taken = 1'b0;
    run_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset asserted mid-cycle: outputs must follow immediately.
    #3;
    rst = 1'b1;
    #1;
    check("rst_pc", pc, RPC);
    check("rst_instr", instr, NOP);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    @(posedge clk);
    #1;
    run_cycle();
    rst = 1'b0;
    run_cycle();

    // Zero-wait fetch then sequential commit.
    st_cnt = 0; rq_cnt = 0;
    phase_fetch = 1'b1;
    #1;
    check("zw_stall_c", {31'd0, stall}, 32'd1);
    run_cycle();
    check("zw_req", {31'd0, imem_req}, 32'd1);
    check("zw_addr", imem_addr, 32'h100);
    phase_fetch = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'h0050_0093;
    run_cycle();
    imem_ack = 1'b0;
    check("zw_stall_c2", {31'd0, stall}, 32'd0);
    run_cycle();
    run_cycle();
    check("zw_stall_cnt", st_cnt, 32'd2);
    check("zw_instr", instr, 32'h0050_0093);
    check("zw_valid", {31'd0, instr_valid}, 32'd1);
    do_commit(1'b0, 32'h0);
    check("zw_pc", pc, 32'h104);
    check("zw_valid_clr", {31'd0, instr_valid}, 32'd0);
    do_commit(1'b1, 32'h0000_0300);
    check("idle_commit_pc", pc, 32'h104);

    // Wait states with phase_fetch held high throughout.
    st_cnt = 0; rq_cnt = 0;
    phase_fetch = 1'b1;
    run_cycle();
    run_cycle();
    run_cycle();
    run_cycle();
    imem_ack   = 1'b1;
    imem_rdata = 32'h00A0_0113;
    run_cycle();
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) run_cycle();
    check("ws_req_cnt", rq_cnt, 32'd4);
    check("ws_stall_cnt", st_cnt, 32'd5);
    check("ws_instr", instr, 32'h00A0_0113);
    phase_fetch = 1'b0;
    run_cycle();

    // Taken branch, then wrap at the top of the address space.
    do_commit(1'b1, 32'h0000_0200);
    check("br_pc", pc, 32'h200);
    do_fetch(32'h0000_0013, 1'b0);
    do_commit(1'b1, 32'hFFFF_FFFC);
    check("br_top_pc", pc, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0013, 1'b0);
    do_commit(1'b0, 32'h0);
    check("wrap_pc", pc, 32'h0);

    // Misaligned branch target faults and freezes the core.
    do_fetch(32'h0000_0033, 1'b0);
    do_commit(1'b1, 32'h0000_0202);
    run_cycle();
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_pc", pc, 32'h0);
    check("mis_stall", {31'd0, stall}, 32'd1);
    check("mis_req", {31'd0, imem_req}, 32'd0);
    do_fetch(32'h1111_1111, 1'b0);
    check("mis_stall_held", {31'd0, stall}, 32'd1);
    do_reset();
    check("mis_rst_fault", {31'd0, fault}, 32'd0);

    // Bus error on the fetch.
    do_fetch(32'hDEAD_BEEF, 1'b1);
    run_cycle();
    check("be_fault", {31'd0, fault}, 32'd1);
    check("be_instr", instr, NOP);
    check("be_valid", {31'd0, instr_valid}, 32'd0);
    check("be_stall", {31'd0, stall}, 32'd1);
    do_commit(1'b0, 32'h0);
    check("be_stall_held", {31'd0, stall}, 32'd1);
    check("be_pc", pc, RPC);
    do_reset();
    check("be_rst_stall", {31'd0, stall}, 32'd0);

    // Reset while a request is outstanding; the late ack must be dropped.
    phase_fetch = 1'b1;
    run_cycle();
    phase_fetch = 1'b0;
    check("mr_req_before", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("mr_req_async", {31'd0, imem_req}, 32'd0);
    check("mr_stall_async", {31'd0, stall}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_cycle();
    imem_ack = 1'b0;
    check("mr_valid", {31'd0, instr_valid}, 32'd0);
    check("mr_req", {31'd0, imem_req}, 32'd0);
    check("mr_instr", instr, NOP);
    phase_fetch = 1'b1;
    run_cycle();
    check("mr_refetch_addr", imem_addr, RPC);
    phase_fetch = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'h0010_0073;
    run_cycle();
    imem_ack = 1'b0;
    check("mr_refetch_instr", instr, 32'h0010_0073);

    // phase_fetch already high at reset release counts as a rise.
    rst = 1'b1;
    phase_fetch = 1'b1;
    run_cycle();
    rst = 1'b0;
    #1;
    check("rel_stall", {31'd0, stall}, 32'd1);
    run_cycle();
    check("rel_req", {31'd0, imem_req}, 32'd1);
    phase_fetch = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
